sweep_sequencer: RTL and testbench

//  Controller that sequences a bounded up/down (triangle) counter sweep between

---
 rtl/sweep_pkg.sv | 14 +
 rtl/sweep_step_alu.sv | 28 ++
 rtl/sweep_sequencer.sv | 140 ++++++++++++++
 tb/tb_sweep_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and default sizes for the triangle sweep sequencer.
package sweep_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_step_alu.sv
// Combinational step unit: x +/- step, saturated to the captured [lo, hi] window.
module sweep_step_alu #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             up,
  output logic [WIDTH-1:0] next
);

  // One extra bit keeps the carry/borrow visible so the clamp never sees a wrapped value.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, x} + {1'b0, step};
  assign diff = {1'b0, x} - {1'b0, step};

  always_comb begin
    if (up) begin
      next = (sum > {1'b0, hi}) ? hi : sum[WIDTH-1:0];
    end else begin
      next = (diff[WIDTH] || (diff[WIDTH-1:0] < lo)) ? lo : diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Runs N lo->hi->lo triangle sweeps of x with pause/abort and busy/done/err status.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [CNT_W-1:0] cfg_sweeps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] x,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] sweep_cnt
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo_q, hi_q, step_q;
  logic [CNT_W-1:0] sweeps_q;
  logic [WIDTH-1:0] x_nxt, alu_next;
  logic [CNT_W-1:0] cnt_nxt, cnt_inc;
  logic             dir_nxt, busy_nxt, done_nxt, err_nxt, capture;
  logic             running;

  assign running = (state == RISE) || (state == FALL);
  assign cnt_inc = sweep_cnt + CNT_W'(1);

  sweep_step_alu #(.WIDTH(WIDTH)) u_alu (
    .x    (x),
    .step (step_q),
    .lo   (lo_q),
    .hi   (hi_q),
    .up   (state == RISE),
    .next (alu_next)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    x_nxt     = x;
    dir_nxt   = dir;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    cnt_nxt   = sweep_cnt;
    capture   = 1'b0;

    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else if (!(pause && running)) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if ((cfg_lo > cfg_hi) || (cfg_step == '0)) begin
              err_nxt = 1'b1;
            end else begin
              capture   = 1'b1;
              x_nxt     = cfg_lo;
              dir_nxt   = 1'b1;
              cnt_nxt   = '0;
              busy_nxt  = 1'b1;
              state_nxt = RISE;
            end
          end
        end
        RISE: begin
          if (x == hi_q) begin
            dir_nxt   = 1'b0;
            state_nxt = FALL;
          end else begin
            x_nxt = alu_next;
          end
        end
        FALL: begin
          if (x == lo_q) begin
            cnt_nxt = cnt_inc;
            if ((sweeps_q != '0) && (cnt_inc == sweeps_q)) begin
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
              state_nxt = DONE;
            end else begin
              dir_nxt   = 1'b1;
              state_nxt = RISE;
            end
          end else begin
            x_nxt = alu_next;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      x         <= '0;
      dir       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      dir       <= dir_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      sweep_cnt <= cnt_nxt;
    end
  end

  // NOTE: the config copies are reset as well; they are few flops and keep the block free of X after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lo_q     <= '0;
      hi_q     <= '0;
      step_q   <= '0;
      sweeps_q <= '0;
    end else if (capture) begin
      lo_q     <= cfg_lo;
      hi_q     <= cfg_hi;
      step_q   <= cfg_step;
      sweeps_q <= cfg_sweeps;
    end
  end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed self-checking bench for sweep_sequencer with hand-computed expectations.
module tb_sweep_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] cfg_lo, cfg_hi, cfg_step;
  logic [7:0] cfg_sweeps;
  logic       pause, abort;
  logic [3:0] x;
  logic       dir, busy, done, err;
  logic [7:0] sweep_cnt;

  int total = 0;
  int bad   = 0;

  sweep_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .cfg_step   (cfg_step),
    .cfg_sweeps (cfg_sweeps),
    .pause      (pause),
    .abort      (abort),
    .x          (x),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sweep_cnt  (sweep_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] st,
                        input logic [7:0] n);
    cfg_lo = lo; cfg_hi = hi; cfg_step = st; cfg_sweeps = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hit15, hit0, jumps, dones, off;
    int prev;
    logic [3:0] exp_x1 [6];
    logic       exp_d1 [6];
    exp_x1 = '{4'd2, 4'd4, 4'd5, 4'd5, 4'd3, 4'd2};
    exp_d1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cfg_lo = '0; cfg_hi = '0; cfg_step = '0; cfg_sweeps = '0;
    #23;
    check("rst_x", x, 0);
    check("rst_dir", dir, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", sweep_cnt, 0);
    reset = 1'b1;
    tick();

    // 1: lo=2 hi=5 step=2, one sweep
    launch(4'd2, 4'd5, 4'd2, 8'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_x%0d", i), x, exp_x1[i]);
      check($sformatf("t1_dir%0d", i), dir, exp_d1[i]);
      check($sformatf("t1_busy%0d", i), busy, 1);
      check($sformatf("t1_done%0d", i), done, 0);
      tick();
    end
    check("t1_done_x", x, 2);
    check("t1_done", done, 1);
    check("t1_done_busy", busy, 0);
    check("t1_cnt", sweep_cnt, 1);
    tick();
    check("t1_done_clr", done, 0);
    check("t1_idle_x", x, 2);

    // 2: full range, two sweeps
    launch(4'd0, 4'd15, 4'd1, 8'd2);
    n = 0; hit15 = 0; hit0 = 0; jumps = 0; dones = 0; prev = -1;
    while (busy && n < 200) begin
      if (x == 4'd15 && prev != 15) hit15++;
      if (x == 4'd0 && prev != 0) hit0++;
      if (prev >= 0 && (int'(x) - prev > 1 || prev - int'(x) > 1)) jumps++;
      if (done) dones++;
      prev = int'(x);
      tick();
      n++;
    end
    if (x == 4'd0 && prev != 0) hit0++;
    check("t2_busy_cycles", n, 64);
    check("t2_hit15", hit15, 2);
    check("t2_hit0", hit0, 3);
    check("t2_jumps", jumps, 0);
    check("t2_done_early", dones, 0);
    check("t2_done", done, 1);
    check("t2_cnt", sweep_cnt, 2);
    tick();
    check("t2_done_once", done, 0);

    // 3: rejected starts
    launch(4'd9, 4'd3, 4'd1, 8'd1);
    check("t3_err_order", err, 1);
    check("t3_busy_order", busy, 0);
    check("t3_x_order", x, 0);
    tick();
    check("t3_err_pulse", err, 0);
    launch(4'd3, 4'd9, 4'd0, 8'd1);
    check("t3_err_step", err, 1);
    check("t3_busy_step", busy, 0);
    check("t3_x_step", x, 0);
    tick();
    check("t3_err_clr", err, 0);
    check("t3_still_idle", busy, 0);

    // 4: endless run, pause at 7, then abort+pause
    launch(4'd0, 4'd15, 4'd1, 8'd0);
    for (int i = 0; i < 7; i++) tick();
    check("t4_at7", x, 7);
    pause = 1'b1;
    off = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (x != 4'd7 || dir != 1'b1 || busy != 1'b1) off++;
    end
    check("t4_pause_hold", off, 0);
    pause = 1'b0;
    tick();
    check("t4_resume", x, 8);
    abort = 1'b1; pause = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    check("t4_abort_busy", busy, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_x", x, 8);
    tick();
    check("t4_idle_done", done, 0);
    check("t4_idle_x", x, 8);

    // 5: lo==hi, three sweeps
    launch(4'd4, 4'd4, 4'd3, 8'd3);
    n = 0; off = 0;
    while (busy && n < 50) begin
      if (x != 4'd4) off++;
      tick();
      n++;
    end
    check("t5_busy_cycles", n, 6);
    check("t5_x_const", off, 0);
    check("t5_done", done, 1);
    check("t5_cnt", sweep_cnt, 3);
    tick();

    // 6: start while busy, then asynchronous reset mid-run
    launch(4'd0, 4'd15, 4'd5, 8'd0);
    for (int i = 0; i < 5; i++) tick();
    check("t6_x10", x, 10);
    check("t6_dir_fall", dir, 0);
    cfg_lo = 4'd9; cfg_hi = 4'd3; cfg_step = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_busy_start_err", err, 0);
    check("t6_busy_start_busy", busy, 1);
    check("t6_busy_start_x", x, 5);
    tick();
    tick();
    check("t6_cnt1", sweep_cnt, 1);
    check("t6_rising", dir, 1);
    tick();
    check("t6_x5", x, 5);
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_x", x, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_dir", dir, 1);
    check("t6_async_cnt", sweep_cnt, 0);
    #2;
    reset = 1'b1;
    tick();
    tick();
    check("t6_post_busy", busy, 0);
    check("t6_post_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
